// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  // Conventional source slots on the writeback port
  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;

  // One pending register write; rd is the destination register
  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } rf_wb_entry_t;

  // 16-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    r = (v == 16'hFFFF) ? v : (v + 16'd1);
    return r;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO holding pending writebacks for one requester.
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = RF_ADDR_W + RF_DATA_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  // A full FIFO refuses pushes even when it is popped in the same cycle
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;
  assign dout  = mem_r[rd_ptr_r];

  // Entry storage; cleared on reset so no stale data survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Read/write pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_SRC
// writeback requesters, each buffered by its own FIFO.
// Pipeline: FIFO head is granted/popped into a stage register, then the
// stage drives the registered write command one cycle later.
// Optional build macro RF_WB_STATS_EN adds conflict_cnt / drop_cnt counters.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int DATA_W     = RF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        req_valid,
  output logic [NUM_SRC-1:0]        req_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] req_reg,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         wr_reg,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      idle
`ifdef RF_WB_STATS_EN
  ,
  output logic [15:0]               conflict_cnt,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int PTR_W   = $clog2(NUM_SRC);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  logic [ENTRY_W-1:0] fifo_dout_s  [NUM_SRC];
  logic [CNT_W-1:0]   fifo_count_s [NUM_SRC];
  logic [NUM_SRC-1:0] fifo_full_s;
  logic [NUM_SRC-1:0] fifo_empty_s;
  logic [NUM_SRC-1:0] push_s;
  logic [NUM_SRC-1:0] pop_s;

  logic [PTR_W-1:0]   rr_ptr_r;
  logic [PTR_W-1:0]   cand_s;
  logic [PTR_W-1:0]   grant_idx_s;
  logic               grant_vld_s;
  logic [ENTRY_W-1:0] head_s;
  logic               all_empty_s;

  logic               stage_vld_r;
  logic [ENTRY_W-1:0] stage_entry_r;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    // Ready depends only on the registered occupancy
    assign req_ready[gi] = !fifo_full_s[gi];
    assign push_s[gi]    = req_valid[gi] && req_ready[gi];

    rf_wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s[gi]),
      .pop   (pop_s[gi]),
      .din   ({req_reg[gi*ADDR_W +: ADDR_W], req_data[gi*DATA_W +: DATA_W]}),
      .dout  (fifo_dout_s[gi]),
      .count (fifo_count_s[gi]),
      .full  (fifo_full_s[gi]),
      .empty (fifo_empty_s[gi])
    );
  end

  // Round-robin search from pointer+1; walking downward lets the nearest
  // non-empty candidate overwrite farther ones
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = rr_ptr_r;
    cand_s      = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand_s      = PTR_W'((int'(rr_ptr_r) + k) % NUM_SRC);
      grant_vld_s = grant_vld_s | ~fifo_empty_s[cand_s];
      grant_idx_s = fifo_empty_s[cand_s] ? grant_idx_s : cand_s;
    end
  end

  // Pop the winning FIFO and select its head entry
  always_comb begin
    pop_s  = '0;
    head_s = fifo_dout_s[grant_idx_s];
    if (grant_vld_s) begin
      pop_s[grant_idx_s] = 1'b1;
    end else begin
      pop_s = '0;
    end
  end

  // Idle needs empty FIFOs, nothing in the stage and no write on the port
  always_comb begin
    all_empty_s = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      all_empty_s = all_empty_s & (fifo_count_s[i] == '0);
    end
  end

  assign idle = all_empty_s && !stage_vld_r && !RegWrite;

  // Round-robin pointer: moves to the winner, holds when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= PTR_W'(NUM_SRC - 1);
    end else if (grant_vld_s) begin
      rr_ptr_r <= grant_idx_s;
    end
  end

  // Grant stage: captures the popped entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld_r   <= 1'b0;
      stage_entry_r <= '0;
    end else begin
      stage_vld_r <= grant_vld_s;
      if (grant_vld_s) begin
        stage_entry_r <= head_s;
      end
    end
  end

  // Registered write command; writes to register 0 are swallowed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      wr_reg   <= '0;
      wr_data  <= '0;
    end else if (stage_vld_r && (stage_entry_r[ENTRY_W-1 -: ADDR_W] != '0)) begin
      RegWrite <= 1'b1;
      wr_reg   <= stage_entry_r[ENTRY_W-1 -: ADDR_W];
      wr_data  <= stage_entry_r[DATA_W-1:0];
    end else begin
      RegWrite <= 1'b0;
    end
  end

`ifdef RF_WB_STATS_EN
  logic multi_busy_s;
  logic drop_s;

  assign multi_busy_s = ($countones(~fifo_empty_s) > 1);
  assign drop_s       = grant_vld_s && (head_s[ENTRY_W-1 -: ADDR_W] == '0);

  // Saturating counters for contention cycles and discarded reg-0 writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= 16'd0;
      drop_cnt     <= 16'd0;
    end else begin
      if (multi_busy_s) begin
        conflict_cnt <= sat_inc16(conflict_cnt);
      end
      if (drop_s) begin
        drop_cnt <= sat_inc16(drop_cnt);
      end
    end
  end
`endif

endmodule
